// File: rtl/dds_pkg.sv
// Shared state type and default widths for the DDS sweep controller.
package dds_pkg;

  localparam int DDS_FREQ_W    = 32;
  localparam int DDS_PHASE_W   = 12;
  localparam int DDS_PHASE_MAX = 360;
  localparam int DDS_DWELL_W   = 24;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LAST = 2'd2
  } dds_state_e;

endpackage

// File: rtl/dds_sweep_ctrl_if.sv
// Control/status bundle between the sweep controller and its register block.
// start/stop are single-cycle request pulses sampled on sclk; there is no ready,
// the controller either takes a start in IDLE or drops it, and stop always wins.
interface dds_sweep_ctrl_if
  import dds_pkg::*;
#(
  parameter int FREQ_W  = DDS_FREQ_W,
  parameter int PHASE_W = DDS_PHASE_W,
  parameter int DWELL_W = DDS_DWELL_W
);

  logic               start;
  logic               stop;
  logic               repeat_en;
  logic [FREQ_W-1:0]  f_start;
  logic [FREQ_W-1:0]  f_stop;
  logic [FREQ_W-1:0]  f_step;
  logic [DWELL_W-1:0] dwell;
  logic [PHASE_W-1:0] phase_cfg;

  logic [FREQ_W-1:0]  freq_ctrl;
  logic [PHASE_W-1:0] phase_ctrl;
  logic               dds_en;
  logic               busy;
  logic               step_stb;
  logic               sweep_done;
  logic               cfg_err;
  dds_state_e         state_dbg;

  modport master (
    output start, stop, repeat_en, f_start, f_stop, f_step, dwell, phase_cfg,
    input  freq_ctrl, phase_ctrl, dds_en, busy, step_stb, sweep_done, cfg_err,
    input  state_dbg
  );

  modport slave (
    input  start, stop, repeat_en, f_start, f_stop, f_step, dwell, phase_cfg,
    output freq_ctrl, phase_ctrl, dds_en, busy, step_stb, sweep_done, cfg_err,
    output state_dbg
  );

endinterface

// File: rtl/dds_dwell_cnt.sv
// Loadable dwell down-counter; expire is high during the last cycle of a dwell.
module dds_dwell_cnt
  import dds_pkg::*;
#(
  parameter int W = DDS_DWELL_W
) (
  input  logic         sclk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W-1:0] cnt;

  // A zero dwell still holds the point for one cycle.
  always_ff @(posedge sclk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= (load_val == '0) ? W'(1) : load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign expire = (cnt == W'(1));

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Linear frequency sweep controller feeding the DDS freq/phase/enable inputs.
// Define SWEEP_DOWN_EN to also accept descending sweeps (f_start > f_stop).
module dds_sweep_ctrl
  import dds_pkg::*;
#(
  parameter int FREQ_W  = DDS_FREQ_W,
  parameter int PHASE_W = DDS_PHASE_W,
  parameter int DWELL_W = DDS_DWELL_W
) (
  input logic             sclk,
  input logic             rst_n,
  dds_sweep_ctrl_if.slave bus
);

  localparam logic [PHASE_W-1:0] PHASE_LIM = PHASE_W'(DDS_PHASE_MAX);

  dds_state_e         state, state_nxt;

  logic [FREQ_W-1:0]  l_start, l_stop, l_step;
  logic [DWELL_W-1:0] l_dwell;

  logic [FREQ_W-1:0]  freq_q, freq_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               run_q, run_d;
  logic               stb_q, stb_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic               expire;
  logic               cnt_load;
  logic [DWELL_W-1:0] cnt_val;

  logic               start_req, cfg_bad, accept, reject;
  logic [FREQ_W:0]    nxt_wide;
  logic               clamp;

  assign start_req = bus.start && !bus.stop;

`ifdef SWEEP_DOWN_EN
  logic dir_down;

  assign cfg_bad = (bus.phase_cfg >= PHASE_LIM) ||
                   ((bus.f_step == '0) && (bus.f_start != bus.f_stop));

  always_ff @(posedge sclk) begin
    if (!rst_n) begin
      dir_down <= 1'b0;
    end else if (accept) begin
      dir_down <= (bus.f_start > bus.f_stop);
    end
  end

  // The extra top bit is the carry (up) or borrow (down) out of the step.
  always_comb begin
    if (dir_down) begin
      nxt_wide = {1'b0, freq_q} - {1'b0, l_step};
      clamp    = nxt_wide[FREQ_W] || (nxt_wide[FREQ_W-1:0] <= l_stop);
    end else begin
      nxt_wide = {1'b0, freq_q} + {1'b0, l_step};
      clamp    = nxt_wide[FREQ_W] || (nxt_wide[FREQ_W-1:0] >= l_stop);
    end
  end
`else
  assign cfg_bad = (bus.phase_cfg >= PHASE_LIM) ||
                   ((bus.f_step == '0) && (bus.f_start != bus.f_stop)) ||
                   (bus.f_start > bus.f_stop);

  // The extra top bit is the carry out of the step.
  always_comb begin
    nxt_wide = {1'b0, freq_q} + {1'b0, l_step};
    clamp    = nxt_wide[FREQ_W] || (nxt_wide[FREQ_W-1:0] >= l_stop);
  end
`endif

  assign accept = (state == IDLE) && start_req && !cfg_bad;
  assign reject = (state == IDLE) && start_req &&  cfg_bad;

  // The first dwell comes straight from the bus; later ones from the latched copy.
  assign cnt_val = (state == IDLE) ? bus.dwell : l_dwell;

  dds_dwell_cnt #(.W(DWELL_W)) u_dwell (
    .sclk     (sclk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_val),
    .expire   (expire)
  );

  always_ff @(posedge sclk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = (bus.f_start == bus.f_stop) ? LAST : RUN;
        end
      end
      RUN: begin
        if (bus.stop) begin
          state_nxt = IDLE;
        end else if (expire && clamp) begin
          state_nxt = LAST;
        end
      end
      LAST: begin
        if (bus.stop) begin
          state_nxt = IDLE;
        end else if (expire) begin
          if (bus.repeat_en) begin
            state_nxt = (l_start == l_stop) ? LAST : RUN;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    freq_d   = freq_q;
    phase_d  = phase_q;
    stb_d    = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    cnt_load = 1'b0;
    unique case (state)
      IDLE: begin
        freq_d = '0;
        err_d  = reject;
        if (accept) begin
          freq_d   = bus.f_start;
          phase_d  = bus.phase_cfg;
          cnt_load = 1'b1;
        end
      end
      RUN: begin
        if (bus.stop) begin
          freq_d = '0;
        end else if (expire) begin
          stb_d    = 1'b1;
          cnt_load = 1'b1;
          freq_d   = clamp ? l_stop : nxt_wide[FREQ_W-1:0];
        end
      end
      LAST: begin
        if (bus.stop) begin
          freq_d = '0;
        end else if (expire) begin
          done_d = 1'b1;
          if (bus.repeat_en) begin
            freq_d   = l_start;
            stb_d    = 1'b1;
            cnt_load = 1'b1;
          end else begin
            freq_d = '0;
          end
        end
      end
      default: freq_d = '0;
    endcase
    run_d = (state_nxt != IDLE);
  end

  always_ff @(posedge sclk) begin
    if (!rst_n) begin
      freq_q  <= '0;
      phase_q <= '0;
      run_q   <= 1'b0;
      stb_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      l_start <= '0;
      l_stop  <= '0;
      l_step  <= '0;
      l_dwell <= '0;
    end else begin
      freq_q  <= freq_d;
      phase_q <= phase_d;
      run_q   <= run_d;
      stb_q   <= stb_d;
      done_q  <= done_d;
      err_q   <= err_d;
      if (accept) begin
        l_start <= bus.f_start;
        l_stop  <= bus.f_stop;
        l_step  <= bus.f_step;
        l_dwell <= bus.dwell;
      end
    end
  end

  assign bus.freq_ctrl  = freq_q;
  assign bus.phase_ctrl = phase_q;
  assign bus.dds_en     = run_q;
  assign bus.busy       = run_q;
  assign bus.step_stb   = stb_q;
  assign bus.sweep_done = done_q;
  assign bus.cfg_err    = err_q;
  assign bus.state_dbg  = state;

endmodule

// File: doc/dds_sweep_ctrl.md
# dds_sweep_ctrl

- Sweep controller that sits directly upstream of the DDS core.
- Generates the core's `freq_ctrl`, `phase_ctrl` and `dds_en` inputs so it steps linearly from a start frequency to a stop frequency.
- Holds each frequency for a programmable dwell time, then ends the sweep or restarts it.
- Configuration is latched at sweep start, so software can rewrite registers mid-sweep without glitching the DDS.

## Interface
- `FREQ_W`, 32, frequency word width in Hz; matches the DDS `freq_ctrl`.
- `PHASE_W`, 12, phase offset width in degrees; matches the DDS `phase_ctrl`.
- `DWELL_W`, 24, dwell counter width in sclk cycles.
- `sclk` in 1: system clock. One clock domain only.
- `rst_n` in 1: reset, synchronous and active-low.
- `start` in 1: single-cycle pulse that requests a sweep.
- `stop` in 1: single-cycle pulse that aborts the sweep.
- `repeat_en` in 1: 1 means restart from `f_start` after the final point.
- `f_start` in FREQ_W: first frequency.
- `f_stop` in FREQ_W: last frequency.
- `f_step` in FREQ_W: frequency increment.
- `dwell` in DWELL_W: cycles each point is held; 0 is treated as 1.
- `phase_cfg` in PHASE_W: phase offset in degrees; legal range 0..359.
- `freq_ctrl` out FREQ_W: frequency to the DDS.
- `phase_ctrl` out PHASE_W: phase to the DDS.
- `dds_en` out 1: enable to the DDS.
- `busy` out 1: high while a sweep is active.
- `step_stb` out 1: one-cycle pulse whenever `freq_ctrl` changes during a run.
- `sweep_done` out 1: one-cycle pulse at the end of each sweep pass.
- `cfg_err` out 1: one-cycle pulse when a `start` is rejected.

## Operation
- **States:** IDLE, RUN, LAST.
- **IDLE:**
  - Outputs: `dds_en`=0, `busy`=0, `freq_ctrl`=0; `phase_ctrl` holds its last value.
  - A `start` is accepted only in IDLE. On acceptance, latch `f_start`, `f_stop`, `f_step`, `dwell` and `phase_cfg`, load `freq_ctrl`=`f_start`, then go to RUN, or to LAST if `f_start`==`f_stop`.
- **Start rejection:** `cfg_err` pulses and the block stays in IDLE when any of these hold:
  - `phase_cfg` ≥ 360.
  - `f_step`==0 with `f_start`≠`f_stop`.
  - `f_start` > `f_stop` with SWEEP_DOWN_EN undefined.
- **RUN:**
  - The dwell counter counts down from the latched `dwell`.
  - On expiry, compute next = `freq_ctrl` + `f_step` in FREQ_W+1 bits.
  - If the carry is set or next ≥ `f_stop`: `freq_ctrl`=`f_stop`, go to LAST.
  - Otherwise: `freq_ctrl`=next, stay in RUN.
  - `step_stb` pulses on every expiry in RUN.
- **LAST:** holds `f_stop` for a full dwell. On expiry, `sweep_done` pulses, then:
  - `repeat_en`=1 (sampled live): `freq_ctrl`=`f_start`, `step_stb` pulses, go to RUN (or stay in LAST for a single-point sweep).
  - `repeat_en`=0: go to IDLE.
- **Stop:**
  - `stop` in RUN or LAST forces IDLE on the next edge. No `sweep_done` pulse.
  - `stop` in IDLE is a no-op.
  - `start` and `stop` in the same cycle: stop wins.
  - `start` while busy is ignored and raises no error.
- **Phase:** `phase_ctrl` = latched `phase_cfg`, constant for the whole sweep.

## Timing
- Reset (`rst_n`=0 at an edge) clears state to IDLE. All outputs and counters are 0 after that edge; reset mid-sweep aborts it silently.
- Start latency: `start` sampled at edge k gives `dds_en`=1, `busy`=1, `freq_ctrl`=`f_start` from edge k+1.
- Each point is held for exactly max(`dwell`,1) cycles, the final point included.
- A sweep from A to B with step S therefore lasts (ceil((B−A)/S)+1)·dwell cycles.
- `sweep_done` is asserted in the first cycle after the final dwell expires:
  - single mode: the same cycle `dds_en` returns to 0;
  - repeat mode: the same cycle `freq_ctrl` returns to `f_start`.
- Repeat restart has no gap: `dds_en` stays high.
- `step_stb` coincides with the first cycle of the new `freq_ctrl` value.
- All outputs are registered. There is no combinational path from input to output.

## Configuration
- SWEEP_DOWN_EN defined:
  - `f_start` > `f_stop` is legal and the sweep descends.
  - next = `freq_ctrl` − `f_step`, computed with a borrow bit.
  - A borrow, or next ≤ `f_stop`, clamps to `f_stop` and goes to LAST.
- SWEEP_DOWN_EN undefined:
  - Only ascending sweeps are supported; `f_start` > `f_stop` raises `cfg_err`.
  - No subtractor is built.

## Structure
- Package `dds_pkg` holds:
  - the state enum (IDLE, RUN, LAST);
  - constants `DDS_FREQ_W`=32, `DDS_PHASE_W`=12, `DDS_PHASE_MAX`=360;
  - the default `DWELL_W`.
- Sub-module `dds_dwell_cnt`:
  - loadable down-counter with ports load, load value and an expire pulse;
  - treats a load value of 0 as 1;
  - instantiated once.

## Test plan
- **Ascending sweep:** `f_start`=1000, `f_stop`=1300, `f_step`=100, `dwell`=4 → `freq_ctrl` is 1000/1100/1200/1300 for 4 cycles each, then `sweep_done`, then `dds_en`=0.
- **Clamp:** `f_start`=1000, `f_stop`=1250, `f_step`=100, `dwell`=2 → 1000, 1100, 1200, 1250.
- **Overflow clamp:** `f_start`=0xFFFF_FF00, `f_stop`=0xFFFF_FFFF, `f_step`=0x200 → second point is 0xFFFF_FFFF; no wrap to a low value.
- **Repeat and stop:** `repeat_en`=1 on the sweep 1000→1100, step 100, `dwell`=3 → 1000,1000,1000,1100,1100,1100,1000…
  - `sweep_done` pulses with each return to 1000.
  - `stop` then gives `dds_en`=0 one cycle later, with no `sweep_done`.
- **Errors:** each of these gives a `cfg_err` pulse and `busy` staying 0:
  - `phase_cfg`=360;
  - `f_step`=0 with 1000→2000;
  - 2000→1000 with the macro undefined.
  - With the macro defined, 2000→1000 step 500 gives 2000, 1500, 1000.
- **Reset and collisions:** `rst_n`=0 mid-RUN → all outputs 0 after the next edge. `start`+`stop` in the same cycle → stays in IDLE. A single-point sweep at 5000 with `dwell`=0 → one cycle at 5000, then `sweep_done`.
